// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: command FIFO in front of an I2C byte engine.
// Queued {cmd, addr, data} entries are issued one at a time with a start
// pulse. The module waits for the engine to accept the command (ready low)
// and then to finish it (ready high). Bytes returned by reads are captured
// into a single holding register. Sticky error flags are raised for
// reserved commands, accept timeouts and read overruns.
// TIMEOUT must be at least 2: the count includes the ISSUE cycle.
module i2c_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic [1:0] push_cmd,
  input  logic [6:0] push_addr,
  input  logic [7:0] push_data,
  output logic [1:0] command,
  output logic [6:0] address,
  output logic [7:0] data,
  output logic       start,
  input  logic       ready,
  input  logic [7:0] i2c_rdata,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       rdata_pop,
  output logic [4:0] level,
  output logic       busy,
  output logic [2:0] err,
  input  logic       err_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACC,
    WAIT_DONE
  } state_e;

  state_e          state_q;
  logic [16:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      level_q, level_d;
  logic [CW-1:0]   cnt_q;
  logic            start_q;
  logic [1:0]      cmd_q;
  logic [6:0]      addr_q;
  logic [7:0]      data_q;
  logic [7:0]      rdata_q;
  logic            rdata_valid_q;
  logic [2:0]      err_q, err_d;

  logic            enq, deq, rsv_push, timeout, capture, overrun;

  // Handshake decode and event strobes shared by the FIFO, FSM and flags
  always_comb begin
    push_ready = (level_q < 5'(DEPTH));
    enq        = push_valid && push_ready && !push_cmd[1];
    rsv_push   = push_valid && push_ready && push_cmd[1];
    deq        = (state_q == IDLE) && (level_q != '0) && ready;
    timeout    = (state_q == WAIT_ACC) && ready && (cnt_q == CW'(TIMEOUT - 1));
    capture    = (state_q == WAIT_DONE) && ready && (cmd_q == 2'b01);
    overrun    = capture && rdata_valid_q && !rdata_pop;
  end

  // Next-state for FIFO pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({enq, deq})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
    // clear first, then OR in this cycle's events so a new error survives err_clr
    err_d = (err_clr ? 3'b000 : err_q) | {overrun, timeout, rsv_push};
  end

  // FIFO storage; contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {push_cmd, push_addr, push_data};
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Issue FSM: dequeue, pulse start, wait for accept, wait for completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (deq) begin
            {cmd_q, addr_q, data_q} <= mem_q[rd_ptr_q];
            start_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= cnt_q + CW'(1);
          state_q <= WAIT_ACC;
        end
        WAIT_ACC: begin
          if (!ready) begin
            state_q <= WAIT_DONE;
          end else if (timeout) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-data holding register and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= '0;
    end else begin
      err_q <= err_d;
      if (capture) begin
        rdata_q       <= i2c_rdata;
        rdata_valid_q <= 1'b1;
      end else if (rdata_pop) begin
        rdata_valid_q <= 1'b0;
      end
    end
  end

  assign command     = cmd_q;
  assign address     = addr_q;
  assign data        = data_q;
  assign start       = start_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign level       = level_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: a transaction-level reference model (command queue
// plus a per-transaction age counter) checked against the DUT every cycle,
// alongside directed scenarios with literal expectations.
module tb_i2c_cmd_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 255;

  logic       clk, rst;
  logic       push_valid, push_ready;
  logic [1:0] push_cmd;
  logic [6:0] push_addr;
  logic [7:0] push_data;
  logic [1:0] command;
  logic [6:0] address;
  logic [7:0] data;
  logic       start, ready;
  logic [7:0] i2c_rdata, rdata;
  logic       rdata_valid, rdata_pop;
  logic [4:0] level;
  logic       busy;
  logic [2:0] err;
  logic       err_clr;

  i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_cmd(push_cmd), .push_addr(push_addr), .push_data(push_data),
    .command(command), .address(address), .data(data), .start(start),
    .ready(ready), .i2c_rdata(i2c_rdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .rdata_pop(rdata_pop),
    .level(level), .busy(busy), .err(err), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] c;
    logic [6:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  ent_t       cur = '0;
  bit         m_act = 0;   // a command has been launched and not yet finished
  int         m_age = 0;   // clock edges since its start pulse was launched
  bit         m_acc = 0;   // engine has taken it (ready seen low)
  logic [7:0] m_rdata = '0;
  bit         m_rv = 0;
  logic [2:0] m_err = '0;

  // monitor records
  int         cyc = 0;
  logic [6:0] start_addrs[$];
  int         start_cyc[$];
  int         err1_rise = -1;
  bit         prev_err1 = 0;

  function automatic int cyc_at(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -1;
  endfunction

  function automatic logic [6:0] addr_at(input int i);
    return (i < start_addrs.size()) ? start_addrs[i] : 7'h7f;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        cur = '0; m_act = 0; m_age = 0; m_acc = 0;
        m_rdata = '0; m_rv = 0; m_err = '0; prev_err1 = 0;
      end else begin
        int   sz;
        bit   acc_ok, enq, resv, cap;
        logic [2:0] ne;
        sz     = mq.size();
        acc_ok = push_valid && (sz < DEPTH);
        enq    = acc_ok && !push_cmd[1];
        resv   = acc_ok && push_cmd[1];
        cap    = 0;
        ne     = {2'b00, resv};
        if (!m_act) begin
          if (sz > 0 && ready) begin
            cur = mq.pop_front();
            m_act = 1; m_age = 0; m_acc = 0;
          end
        end else begin
          m_age++;
          if (m_age >= 2) begin
            if (!m_acc) begin
              if (!ready) m_acc = 1;
              else if (m_age == TIMEOUT) begin
                ne[1] = 1'b1;
                m_act = 0;
              end
            end else if (ready) begin
              m_act = 0;
              cap = (cur.c == 2'b01);
            end
          end
        end
        if (enq) mq.push_back('{push_cmd, push_addr, push_data});
        if (cap) begin
          if (m_rv && !rdata_pop) ne[2] = 1'b1;
          m_rdata = i2c_rdata;
          m_rv = 1;
        end else if (rdata_pop) begin
          m_rv = 0;
        end
        m_err = (err_clr ? 3'b000 : m_err) | ne;

        #2;
        cyc++;
        if (!rst) begin
          chk("level",       32'(level),       32'(mq.size()));
          chk("push_ready",  32'(push_ready),  32'(mq.size() < DEPTH));
          chk("start",       32'(start),       32'(m_act && m_age == 0));
          chk("busy",        32'(busy),        32'(m_act || mq.size() > 0));
          chk("rdata",       32'(rdata),       32'(m_rdata));
          chk("rdata_valid", 32'(rdata_valid), 32'(m_rv));
          chk("err",         32'(err),         32'(m_err));
          chk("command",     32'(command),     32'(cur.c));
          chk("address",     32'(address),     32'(cur.a));
          chk("data",        32'(data),        32'(cur.d));
          if (start) begin
            start_addrs.push_back(address);
            start_cyc.push_back(cyc);
          end
          if (err[1] && !prev_err1) err1_rise = cyc;
          prev_err1 = err[1];
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic push(input logic [1:0] c, input logic [6:0] a, input logic [7:0] d);
    push_valid = 1'b1; push_cmd = c; push_addr = a; push_data = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Engine: wait for a start pulse, drop ready acc_dly negedges later,
  // raise it again busy_len negedges after that with rb on i2c_rdata.
  task automatic engine_txn(input int acc_dly, input int busy_len, input logic [7:0] rb);
    int n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!start && n < 50);
    chk("start_seen", 32'(start), 32'd1);
    repeat (acc_dly) @(negedge clk);
    ready = 1'b0;
    i2c_rdata = rb;
    repeat (busy_len) @(negedge clk);
    ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n0;
    rst = 1'b1;
    push_valid = 0; push_cmd = '0; push_addr = '0; push_data = '0;
    ready = 1'b1; i2c_rdata = '0; rdata_pop = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single write
    n0 = start_addrs.size();
    push(2'b00, 7'h50, 8'hA5);
    chk("wr_level1", 32'(level), 32'd1);
    chk("wr_model_level1", 32'(mq.size()), 32'd1);
    engine_txn(2, 10, 8'h00);
    repeat (2) @(negedge clk);
    chk("wr_level0", 32'(level), 32'd0);
    chk("wr_one_start", 32'(start_addrs.size() - n0), 32'd1);
    chk("wr_addr", 32'(address), 32'h50);
    chk("wr_data", 32'(data), 32'hA5);
    chk("wr_cmd", 32'(command), 32'd0);
    chk("wr_no_rvalid", 32'(rdata_valid), 32'd0);

    // single read, then pop
    push(2'b01, 7'h68, 8'h00);
    engine_txn(2, 5, 8'h3C);
    @(negedge clk);
    chk("rd_rdata", 32'(rdata), 32'h3C);
    chk("rd_rvalid", 32'(rdata_valid), 32'd1);
    chk("rd_model_rdata", 32'(m_rdata), 32'h3C);
    rdata_pop = 1'b1;
    @(negedge clk);
    rdata_pop = 1'b0;
    chk("rd_popped", 32'(rdata_valid), 32'd0);

    // full: first entry goes out, next four stored, sixth refused
    n0 = start_addrs.size();
    for (int i = 0; i < 6; i++) begin
      push_valid = 1'b1; push_cmd = 2'b00;
      push_addr = 7'(7'h10 + i); push_data = 8'(i);
      if (i == 2) ready = 1'b0;
      @(negedge clk);
    end
    push_valid = 1'b0;
    chk("full_level", 32'(level), 32'd4);
    chk("full_push_ready", 32'(push_ready), 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) engine_txn(2, 3, 8'h00);
    repeat (3) @(negedge clk);
    chk("full_nstarts", 32'(start_addrs.size() - n0), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("full_order", 32'(addr_at(n0 + i)), 32'(7'h10 + i));
    chk("full_drained", 32'(level), 32'd0);

    // accept timeout, then the next queued entry still goes out
    n0 = start_cyc.size();
    push(2'b00, 7'h20, 8'h01);
    push(2'b00, 7'h21, 8'h02);
    begin
      int n = 0;
      do begin
        @(posedge clk); #2; n++;
      end while (!err[1] && n < 400);
    end
    chk("to_seen", 32'(err[1]), 32'd1);
    chk("to_gap", 32'(err1_rise - cyc_at(n0)), 32'd255);
    engine_txn(2, 3, 8'h00);
    repeat (3) @(negedge clk);
    chk("to_next_addr", 32'(addr_at(n0 + 1)), 32'h21);
    chk("to_err", 32'(err), 32'b010);
    chk("to_level", 32'(level), 32'd0);

    // overrun, reserved command, clear, set-beats-clear
    clr_err();
    chk("clr_err", 32'(err), 32'd0);
    push(2'b01, 7'h30, 8'h00);
    engine_txn(2, 3, 8'h11);
    @(negedge clk);
    push(2'b01, 7'h31, 8'h00);
    engine_txn(2, 3, 8'h22);
    @(negedge clk);
    chk("ov_rdata", 32'(rdata), 32'h22);
    chk("ov_rvalid", 32'(rdata_valid), 32'd1);
    chk("ov_err", 32'(err), 32'b100);
    push(2'b10, 7'h40, 8'h00);
    chk("rsv_level", 32'(level), 32'd0);
    chk("rsv_err", 32'(err), 32'b101);
    push_valid = 1'b1; push_cmd = 2'b11; push_addr = 7'h41; err_clr = 1'b1;
    @(negedge clk);
    push_valid = 1'b0; err_clr = 1'b0;
    chk("set_wins", 32'(err), 32'b001);
    chk("set_wins_level", 32'(level), 32'd0);
    clr_err();
    chk("clr_err2", 32'(err), 32'd0);
    rdata_pop = 1'b1;
    @(negedge clk);
    rdata_pop = 1'b0;

    // asynchronous reset during WAIT_DONE with three entries queued
    push(2'b10, 7'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_cmd = 2'b00;
      push_addr = 7'(7'h60 + i); push_data = 8'(i);
      if (i == 2) ready = 1'b0;
      @(negedge clk);
    end
    push_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_err", 32'(err), 32'b001);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_start", 32'(start), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_push_ready", 32'(push_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    n0 = start_addrs.size();
    repeat (10) @(negedge clk);
    chk("post_rst_nostart", 32'(start_addrs.size() - n0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_queue.md
I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles to wait for I2C engine acceptance.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 push_valid  in  1  host requests enqueue of one command.
REQ-006 push_ready  out  1  queue can accept; enqueue occurs when push_valid && push_ready.
REQ-007 push_cmd  in  2  00 = write byte, 01 = read byte, 1x = reserved.
REQ-008 push_addr  in  7  I2C slave address.
REQ-009 push_data  in  8  write payload (ignored for reads).
REQ-010 command  out  2  command presented to the I2C engine.
REQ-011 address  out  7  slave address presented to the I2C engine.
REQ-012 data  out  8  write byte presented to the I2C engine.
REQ-013 start  out  1  one-cycle pulse launching an I2C transaction.
REQ-014 ready  in  1  I2C engine idle (high) / busy (low).
REQ-015 i2c_rdata  in  8  byte returned by the engine; valid when ready rises after a read.
REQ-016 rdata  out  8  last captured read byte.
REQ-017 rdata_valid  out  1  rdata holds an unconsumed byte.
REQ-018 rdata_pop  in  1  host consumes rdata.
REQ-019 level  out  5  FIFO occupancy, 0..DEPTH.
REQ-020 busy  out  1  FSM not in IDLE or FIFO non-empty.
REQ-021 err  out  3  sticky flags: [0] reserved cmd, [1] accept timeout, [2] read overrun.
REQ-022 err_clr  in  1  clears all err bits.

Function
REQ-023 FIFO SHALL store {cmd, addr, data}; push_ready = (level < DEPTH); no bypass while full, even on same-cycle dequeue.
REQ-024 Pointers SHALL wrap modulo DEPTH; level SHALL increase by 1 on enqueue, decrease by 1 on dequeue, unchanged on both same cycle.
REQ-025 Enqueue of reserved cmd (1x) SHALL NOT store the entry and SHALL set err[0] (push_ready unaffected).
REQ-026 FSM states: IDLE, ISSUE, WAIT_ACC, WAIT_DONE.
REQ-027 IDLE -> ISSUE when FIFO non-empty and ready=1; head dequeued into command/address/data registers that cycle.
REQ-028 ISSUE: start=1 for exactly one cycle; -> WAIT_ACC next cycle.
REQ-029 WAIT_ACC: ready=0 -> WAIT_DONE; TIMEOUT cycles elapsed with ready=1 -> set err[1], -> IDLE, command dropped (no retry).
REQ-030 WAIT_DONE: ready=1 -> IDLE; if command was read, capture i2c_rdata into rdata and set rdata_valid same edge.
REQ-031 Capture while rdata_valid=1 and no rdata_pop SHALL overwrite rdata and set err[2].
REQ-032 Capture and rdata_pop same cycle: rdata takes new byte, rdata_valid stays 1, no err[2].
REQ-033 rdata_pop with no capture SHALL clear rdata_valid; pop while invalid is ignored.
REQ-034 err_clr and a new error same cycle: new error bit SHALL be set (set wins).
REQ-035 command/address/data SHALL hold stable from ISSUE until leaving WAIT_DONE.
REQ-036 Minimum issue-to-issue spacing: 1 idle cycle between WAIT_DONE exit and next ISSUE.

Reset
REQ-037 On rst: FIFO empty, level=0, push_ready=1, FSM=IDLE, start=0, command=0, address=0, data=0, rdata=0, rdata_valid=0, err=0, busy=0.
REQ-038 rst mid-transaction SHALL abandon the in-flight command and all queued entries; no start pulse on release until a new enqueue.

Verification
REQ-039 Write: push {00,0x50,0xA5}, engine drops ready 2 cycles after start, raises 10 cycles later -> one start pulse, address=0x50, data=0xA5, rdata_valid stays 0, level 1->0.
REQ-040 Read: push {01,0x68,x}, engine returns i2c_rdata=0x3C -> rdata=0x3C, rdata_valid=1 on ready rise; rdata_pop -> rdata_valid=0.
REQ-041 Full: ready held low, push 5 commands with DEPTH=4 -> first dequeued, next 4 stored, push_ready=0 at level=4, 6th push not stored.
REQ-042 Timeout: ready held high after start, TIMEOUT=255 -> err[1]=1 exactly 255 cycles after start, FSM IDLE, next entry issued.
REQ-043 Overrun and errors: two reads without pop -> rdata = second byte, err[2]=1; push cmd 10 -> err[0]=1, level unchanged; err_clr -> err=0.
REQ-044 Reset: assert rst during WAIT_DONE with level=3 -> immediately level=0, start=0, err=0, busy=0, asynchronously without a clock edge.
